output_display: RTL and testbench
=================================

Name: output_display

Overview:
- Downstream consumer of the processor's output port (outval1, outval2, outsel, outdisplay).
- Each OUT event stores outval1 into one of 8 slot registers selected by outsel, and stores outval2 into an auxiliary register.
- The block scans an 8-digit multiplexed 7-segment display:
  - digits 7..4 show the hex value of the slot chosen by board switches;
  - digits 3..0 show the aux register.
- Also provides write-indicator LEDs and an OUT event counter for debug.

Parameters:
SCAN_DIV, 50000, clock cycles each digit stays lit; legal range 2..2^20.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
outdisplay  input  1  OUT strobe from processor; each high cycle is one write event
outsel  input  3  destination slot index for the OUT event
outval1  input  16  value written to slot[outsel]
outval2  input  16  value written to aux register
view_sel  input  3  slot shown on digits 7..4 (asynchronous switch input, used directly)
seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
an_n  output  8  digit enables, active-low one-hot, registered
led  output  8  one-hot marker of the most recently written slot, registered
out_count  output  16  number of OUT events, saturating, registered

Behaviour:
- Reset (async, while high):
  - slots[0..7] = 0, slot_valid[7:0] = 0, aux = 0, aux_valid = 0.
  - Prescaler = 0, digit index = 0.
  - seg_n = 7'h7F, an_n = 8'hFF, led = 0, out_count = 0.
  - Reset asserted mid-scan or mid-write aborts everything; a write in the same cycle as reset is lost.
- Write (rising edge with outdisplay = 1):
  - slot[outsel] <= outval1, slot_valid[outsel] <= 1.
  - aux <= outval2, aux_valid <= 1.
  - led <= 1 << outsel.
  - out_count <= out_count + 1, holding at 16'hFFFF.
  - If outdisplay is held high for N cycles, that is N writes; the last one wins.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and the digit index advances 0→1→…→7→0.
  - Each digit index therefore lasts exactly SCAN_DIV cycles, and a full frame is 8·SCAN_DIV cycles.
- Digit source:
  - Digit i in 0..3 shows aux nibble [4i+3:4i].
  - Digit i in 4..7 shows slot[view_sel] nibble [4(i-4)+3:4(i-4)].
  - When the source's valid bit is 0, the digit shows a dash (segment g only): seg_n = 7'b0111111.
- Output register:
  - Every cycle, an_n <= ~(1 << digit) and seg_n <= pattern(selected nibble).
  - Outputs lag digit/slot/view_sel changes by exactly one cycle.
  - First clock after reset: an_n = 8'hFE.
- Hex patterns (seg_n, gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Simultaneous write and display of the same slot:
  - The register updates at edge k and seg_n shows the new value at edge k+1.
  - No glitch value is permitted other than old→new.
- Only one digit is enabled at any time. an_n is never all-zero.

Test Plan:
- Reset release, SCAN_DIV=4, no writes → an_n=FE at cycle 1; steps FD,FB,…,7F every 4 cycles, back to FE at cycle 33; seg_n=0111111 on every digit.
- outdisplay 1 cycle with outsel=3, outval1=16'h12AF, outval2=16'h00C5, view_sel=3 → led=8'h08, out_count=1. Digits 7..4 show 1,2,A,F; digits 3..0 show 0,0,C,5 (seg_n 1000000,1000000,1000110,0010010).
- Write slot2=16'h8888, view_sel toggled 3→2 → digits 7..4 change to 8 (0000000) one cycle after view_sel changes; slot3 value is retained when switching back.
- outdisplay held high 3 cycles with outsel 0,1,5 → slot5 holds the last value, led=8'h20, out_count=+3.
- Force out_count to 16'hFFFE (65534 writes or preload), then 3 writes → out_count stays 16'hFFFF.
- Reset pulse mid-frame after writes → all outputs return to reset values immediately (async), and digits show dashes afterwards.

Source files
------------

// File: rtl/output_display.sv
// Output-port consumer: latches OUT events into 8 slot registers plus an aux
// register, and scans them onto an 8-digit multiplexed 7-segment display.
module output_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        outdisplay,
  input  logic [2:0]  outsel,
  input  logic [15:0] outval1,
  input  logic [15:0] outval2,
  input  logic [2:0]  view_sel,
  output logic [6:0]  seg_n,
  output logic [7:0]  an_n,
  output logic [7:0]  led,
  output logic [15:0] out_count
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [6:0] DASH = 7'b0111111;

  logic [15:0]   slots [8];
  logic [7:0]    slot_valid;
  logic [15:0]   aux;
  logic          aux_valid;
  logic [PW-1:0] presc;
  logic [2:0]    digit;

  logic [15:0]   src_word;
  logic          src_valid;
  logic [3:0]    nibble;
  logic [6:0]    seg_next;

  function automatic logic [6:0] hex_pattern(input logic [3:0] v);
    logic [6:0] p;
    p = 7'b1111111;
    case (v)
      4'h0: p = 7'b1000000;
      4'h1: p = 7'b1111001;
      4'h2: p = 7'b0100100;
      4'h3: p = 7'b0110000;
      4'h4: p = 7'b0011001;
      4'h5: p = 7'b0010010;
      4'h6: p = 7'b0000010;
      4'h7: p = 7'b1111000;
      4'h8: p = 7'b0000000;
      4'h9: p = 7'b0010000;
      4'hA: p = 7'b0001000;
      4'hB: p = 7'b0000011;
      4'hC: p = 7'b1000110;
      4'hD: p = 7'b0100001;
      4'hE: p = 7'b0000110;
      4'hF: p = 7'b0001110;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Upper four digits follow the switch-selected slot, lower four the aux register.
  always_comb begin
    src_word  = aux;
    src_valid = aux_valid;
    if (digit[2]) begin
      src_word  = slots[view_sel];
      src_valid = slot_valid[view_sel];
    end
    nibble = 4'h0;
    case (digit[1:0])
      2'd0: nibble = src_word[3:0];
      2'd1: nibble = src_word[7:4];
      2'd2: nibble = src_word[11:8];
      2'd3: nibble = src_word[15:12];
      default: nibble = 4'h0;
    endcase
    seg_next = src_valid ? hex_pattern(nibble) : DASH;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) slots[i] <= '0;
      slot_valid <= '0;
      aux        <= '0;
      aux_valid  <= 1'b0;
      led        <= '0;
      out_count  <= '0;
    end else if (outdisplay) begin
      slots[outsel]      <= outval1;
      slot_valid[outsel] <= 1'b1;
      aux                <= outval2;
      aux_valid          <= 1'b1;
      led                <= 8'd1 << outsel;
      if (out_count != 16'hFFFF) out_count <= out_count + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= '0;
      digit <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      digit <= digit + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_n <= '1;
      an_n  <= '1;
    end else begin
      seg_n <= seg_next;
      an_n  <= ~(8'd1 << digit);
    end
  end

endmodule

// File: tb/tb_output_display.sv
// Directed self-checking bench for output_display with a short scan period.
module tb_output_display;

  localparam int unsigned SCAN_DIV = 4;
  localparam logic [6:0] DASH = 7'b0111111;

  logic        clock;
  logic        reset;
  logic        outdisplay;
  logic [2:0]  outsel;
  logic [15:0] outval1;
  logic [15:0] outval2;
  logic [2:0]  view_sel;
  logic [6:0]  seg_n;
  logic [7:0]  an_n;
  logic [7:0]  led;
  logic [15:0] out_count;

  int passed;
  int total;

  output_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clock(clock),
    .reset(reset),
    .outdisplay(outdisplay),
    .outsel(outsel),
    .outval1(outval1),
    .outval2(outval2),
    .view_sel(view_sel),
    .seg_n(seg_n),
    .an_n(an_n),
    .led(led),
    .out_count(out_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Waits (bounded) until the given digit is being driven; samples on negedge.
  task automatic wait_digit(input int d, output logic ok);
    logic [7:0] target;
    target = ~(8'd1 << d);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (an_n === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_an;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (seg_n !== 7'h7F) $display("FAIL reset_seg got=%h want=7f", seg_n); else passed++;
    total++; if (an_n !== 8'hFF) $display("FAIL reset_an got=%h want=ff", an_n); else passed++;
    total++; if (led !== 8'h00) $display("FAIL reset_led got=%h want=00", led); else passed++;
    total++; if (out_count !== 16'h0) $display("FAIL reset_count got=%h want=0000", out_count); else passed++;
    reset = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clock);
      exp_an = ~(8'd1 << (((n - 1) / 4) % 8));
      total++;
      if (an_n !== exp_an) $display("FAIL scan_an cycle=%0d got=%h want=%h", n, an_n, exp_an);
      else passed++;
      total++;
      if (seg_n !== DASH) $display("FAIL scan_dash cycle=%0d got=%b want=%b", n, seg_n, DASH);
      else passed++;
    end
  endtask

  task automatic test_write();
    logic [6:0] exp_seg [8];
    logic ok;
    exp_seg = '{7'b0010010, 7'b1000110, 7'b1000000, 7'b1000000,
                7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    outdisplay = 1'b1; outsel = 3'd3; outval1 = 16'h12AF; outval2 = 16'h00C5; view_sel = 3'd3;
    @(negedge clock);
    outdisplay = 1'b0;
    total++; if (led !== 8'h08) $display("FAIL write_led got=%h want=08", led); else passed++;
    total++; if (out_count !== 16'd1) $display("FAIL write_count got=%h want=0001", out_count); else passed++;
    for (int d = 0; d < 8; d++) begin
      wait_digit(d, ok);
      total++;
      if (!ok) $display("FAIL write_digit%0d timeout an_n=%h", d, an_n);
      else if (seg_n !== exp_seg[d]) $display("FAIL write_digit%0d got=%b want=%b", d, seg_n, exp_seg[d]);
      else passed++;
    end
  endtask

  task automatic test_view_switch();
    logic ok1, ok2;
    outdisplay = 1'b1; outsel = 3'd2; outval1 = 16'h8888; outval2 = 16'h00C5;
    @(negedge clock);
    outdisplay = 1'b0;
    total++; if (out_count !== 16'd2) $display("FAIL view_count got=%h want=0002", out_count); else passed++;
    wait_digit(3, ok1);
    wait_digit(4, ok2);
    total++;
    if (!(ok1 && ok2)) $display("FAIL view_wait timeout an_n=%h", an_n);
    else if (seg_n !== 7'b0001110) $display("FAIL view_before got=%b want=0001110", seg_n);
    else passed++;
    view_sel = 3'd2;
    @(negedge clock);
    total++; if (an_n !== 8'hEF) $display("FAIL view_an got=%h want=ef", an_n); else passed++;
    total++; if (seg_n !== 7'b0000000) $display("FAIL view_slot2 got=%b want=0000000", seg_n); else passed++;
    view_sel = 3'd3;
    @(negedge clock);
    total++; if (seg_n !== 7'b0001110) $display("FAIL view_slot3_kept got=%b want=0001110", seg_n); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_seg [8];
    logic ok;
    exp_seg = '{7'b0001110, 7'b0000110, 7'b0000110, 7'b0000011,
                7'b0001000, 7'b0010010, 7'b0001000, 7'b0010010};
    outdisplay = 1'b1; outsel = 3'd0; outval1 = 16'h1111; outval2 = 16'h0001;
    @(negedge clock);
    outsel = 3'd1; outval1 = 16'h2222; outval2 = 16'h0002;
    @(negedge clock);
    outsel = 3'd5; outval1 = 16'h5A5A; outval2 = 16'hBEEF;
    @(negedge clock);
    outdisplay = 1'b0;
    view_sel = 3'd5;
    total++; if (led !== 8'h20) $display("FAIL b2b_led got=%h want=20", led); else passed++;
    total++; if (out_count !== 16'd5) $display("FAIL b2b_count got=%h want=0005", out_count); else passed++;
    for (int d = 0; d < 8; d++) begin
      wait_digit(d, ok);
      total++;
      if (!ok) $display("FAIL b2b_digit%0d timeout an_n=%h", d, an_n);
      else if (seg_n !== exp_seg[d]) $display("FAIL b2b_digit%0d got=%b want=%b", d, seg_n, exp_seg[d]);
      else passed++;
    end
    view_sel = 3'd0;
    wait_digit(4, ok);
    total++;
    if (!ok) $display("FAIL b2b_slot0 timeout an_n=%h", an_n);
    else if (seg_n !== 7'b1111001) $display("FAIL b2b_slot0 got=%b want=1111001", seg_n);
    else passed++;
  endtask

  task automatic test_saturate();
    outsel = 3'd6; outval1 = 16'h1234; outval2 = 16'h4321;
    outdisplay = 1'b1;
    repeat (65529) @(negedge clock);
    outdisplay = 1'b0;
    total++; if (out_count !== 16'hFFFE) $display("FAIL sat_fffe got=%h want=fffe", out_count); else passed++;
    outdisplay = 1'b1;
    @(negedge clock);
    total++; if (out_count !== 16'hFFFF) $display("FAIL sat_first got=%h want=ffff", out_count); else passed++;
    repeat (2) @(negedge clock);
    outdisplay = 1'b0;
    total++; if (out_count !== 16'hFFFF) $display("FAIL sat_hold got=%h want=ffff", out_count); else passed++;
    total++; if (led !== 8'h40) $display("FAIL sat_led got=%h want=40", led); else passed++;
  endtask

  task automatic test_reset_mid();
    logic ok;
    wait_digit(2, ok);
    total++; if (!ok) $display("FAIL rst_mid_wait timeout an_n=%h", an_n); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (seg_n !== 7'h7F) $display("FAIL rst_mid_seg got=%h want=7f", seg_n); else passed++;
    total++; if (an_n !== 8'hFF) $display("FAIL rst_mid_an got=%h want=ff", an_n); else passed++;
    total++; if (led !== 8'h00) $display("FAIL rst_mid_led got=%h want=00", led); else passed++;
    total++; if (out_count !== 16'h0) $display("FAIL rst_mid_count got=%h want=0000", out_count); else passed++;
    @(negedge clock);
    reset = 1'b0;
    view_sel = 3'd5;
    @(negedge clock);
    total++; if (an_n !== 8'hFE) $display("FAIL rst_mid_first got=%h want=fe", an_n); else passed++;
    wait_digit(7, ok);
    total++;
    if (!ok) $display("FAIL rst_mid_d7 timeout an_n=%h", an_n);
    else if (seg_n !== DASH) $display("FAIL rst_mid_d7 got=%b want=%b", seg_n, DASH);
    else passed++;
    wait_digit(0, ok);
    total++;
    if (!ok) $display("FAIL rst_mid_d0 timeout an_n=%h", an_n);
    else if (seg_n !== DASH) $display("FAIL rst_mid_d0 got=%b want=%b", seg_n, DASH);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    reset = 1'b1;
    outdisplay = 1'b0;
    outsel = '0;
    outval1 = '0;
    outval2 = '0;
    view_sel = '0;
    test_reset();
    test_write();
    test_view_switch();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
